score_tracker: RTL



---
 rtl/score_tracker.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/score_tracker.sv
// Score, streak, level and high-score engine for the Tetris core, plus a
// sequential double-dabble converter that keeps a BCD copy of the score.
module score_tracker #(
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned MAX_SCORE  = 9999,
  parameter int unsigned LINES_W    = 3,
  parameter int unsigned STREAK_MAX = 3,
  parameter int unsigned STREAK_W   = 2,
  parameter int unsigned LEVEL_W    = 4,
  parameter int unsigned LEVEL_STEP = 20,
  parameter int unsigned DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  place_valid,
  input  logic [LINES_W-1:0]    lines_cleared,
  input  logic                  game_reset,
  input  logic [LEVEL_W-1:0]    level_offset,
  output logic [SCORE_W-1:0]    score,
  output logic [STREAK_W-1:0]   streaks,
  output logic [LEVEL_W-1:0]    level,
  output logic [SCORE_W-1:0]    high_score,
  output logic                  new_high,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int unsigned SUM_W  = SCORE_W + 1;
  localparam int unsigned STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned SR_W   = BCD_W + SCORE_W;
  localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);

  localparam logic [SCORE_W-1:0]  MAX_S      = SCORE_W'(MAX_SCORE);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);
  localparam logic [CNT_W-1:0]    LAST_SHIFT = CNT_W'(SCORE_W - 1);

  typedef enum logic {
    CONV_IDLE,
    CONV_SHIFT
  } conv_state_t;

  logic [SCORE_W-1:0]  score_q, score_d;
  logic [STREAK_W-1:0] streaks_q, streaks_d;
  logic [LEVEL_W-1:0]  base_level_q, base_level_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [SCORE_W-1:0]  high_score_q, high_score_d;
  logic                new_high_q, new_high_d;

  logic [SUM_W-1:0]    add, score_sum, step_sum;
  logic [LEVEL_W:0]    level_sum;

  conv_state_t         conv_state_q;
  logic [SR_W-1:0]     sr_q, sr_adj, sr_shift;
  logic [CNT_W-1:0]    cnt_q;
  logic [SCORE_W-1:0]  conv_src_q;
  logic [BCD_W-1:0]    bcd_q;

  always_comb begin
    add       = SUM_W'(lines_cleared) + SUM_W'(streaks_q);
    score_sum = SUM_W'(score_q) + add;
    step_sum  = SUM_W'(step_cnt_q) + add;

    score_d      = score_q;
    streaks_d    = streaks_q;
    base_level_d = base_level_q;
    step_cnt_d   = step_cnt_q;
    high_score_d = high_score_q;
    new_high_d   = 1'b0;

    // game_reset takes priority; a coincident placement is discarded and the
    // high-score comparison sees the score from before this cycle.
    if (game_reset) begin
      if (score_q > high_score_q) begin
        high_score_d = score_q;
        new_high_d   = 1'b1;
      end
      score_d      = '0;
      streaks_d    = '0;
      base_level_d = '0;
      step_cnt_d   = '0;
    end else if (place_valid) begin
      score_d = (score_sum >= SUM_W'(MAX_SCORE)) ? MAX_S : score_sum[SCORE_W-1:0];

      if (lines_cleared == '0)
        streaks_d = '0;
      else if (streaks_q >= STREAK_TOP)
        streaks_d = STREAK_TOP;
      else
        streaks_d = streaks_q + 1'b1;

      // Subtract-and-carry replaces a score/LEVEL_STEP divider; it works
      // because one placement can never add LEVEL_STEP or more points.
      if (score_q != MAX_S) begin
        if (step_sum >= SUM_W'(LEVEL_STEP)) begin
          step_cnt_d = STEP_W'(step_sum - SUM_W'(LEVEL_STEP));
          if (base_level_q != '1)
            base_level_d = base_level_q + 1'b1;
        end else begin
          step_cnt_d = STEP_W'(step_sum);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score_q      <= '0;
      streaks_q    <= '0;
      base_level_q <= '0;
      step_cnt_q   <= '0;
      high_score_q <= '0;
      new_high_q   <= 1'b0;
    end else begin
      score_q      <= score_d;
      streaks_q    <= streaks_d;
      base_level_q <= base_level_d;
      step_cnt_q   <= step_cnt_d;
      high_score_q <= high_score_d;
      new_high_q   <= new_high_d;
    end
  end

  always_comb begin
    level_sum = {1'b0, base_level_q} + {1'b0, level_offset};
    level     = level_sum[LEVEL_W] ? base_level_q : level_sum[LEVEL_W-1:0];
  end

  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr_q[SCORE_W + 4*i +: 4] >= 4'd5)
        sr_adj[SCORE_W + 4*i +: 4] = sr_q[SCORE_W + 4*i +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  // bcd is only written on the last shift, so it never shows a partial value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      conv_state_q <= CONV_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      conv_src_q   <= '0;
      bcd_q        <= '0;
    end else begin
      case (conv_state_q)
        CONV_IDLE: begin
          if (score_q != conv_src_q) begin
            sr_q         <= {{BCD_W{1'b0}}, score_q};
            conv_src_q   <= score_q;
            cnt_q        <= '0;
            conv_state_q <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          sr_q  <= sr_shift;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            bcd_q        <= sr_shift[SR_W-1 -: BCD_W];
            conv_state_q <= CONV_IDLE;
          end
        end
        default: conv_state_q <= CONV_IDLE;
      endcase
    end
  end

  assign score      = score_q;
  assign streaks    = streaks_q;
  assign high_score = high_score_q;
  assign new_high   = new_high_q;
  assign bcd        = bcd_q;
  assign bcd_valid  = (conv_state_q == CONV_IDLE) && (score_q == conv_src_q);

endmodule
